// File: rtl/serial_m_of_n_checker_pkg.sv
// Shared definitions for the serial M-of-N symbol checker.
package SerialMofNDefs;

    typedef logic bool_t;

    // HUNT: waiting for a sync; COLLECT: assembling symbols.
    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam int DEF_N     = 5;
    localparam int DEF_M     = 2;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/serial_m_of_n_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// When clr and inc arrive in the same cycle, the clear is applied first,
// so the count becomes 1.
module sat_counter
    import SerialMofNDefs::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Count increments, hold at all-ones, clear-then-increment on collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/serial_m_of_n_checker.sv
// Serial M-of-N checker: collects N-bit symbols from a gated serial stream
// aligned by sync, and flags symbols whose ones count differs from M.
// A sticky flag records any error. The saturating error counter exists only
// when SERIAL_MOFN_ERRCNT_EN is defined; otherwise err_count is tied to 0.
// Handshake: serial_in is consumed on every rising clk edge where
// bit_valid=1; there is no back-pressure.
// dbg_state is 1 while the FSM is in COLLECT.
module serial_m_of_n_checker
    import SerialMofNDefs::*;
#(
    parameter int N     = DEF_N,
    parameter int M     = DEF_M,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             bit_valid,
    input  logic             serial_in,
    input  logic             sync,
    input  logic             clear_err,
    output logic             sym_done,
    output logic             sym_error,
    output logic             sym_abort,
    output logic             sticky_err,
    output logic [CNT_W-1:0] err_count,
    output logic             dbg_state
);

    localparam int IDX_W  = $clog2(N);
    localparam int ONES_W = $clog2(N + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);
    localparam logic [ONES_W-1:0] M_ONES   = ONES_W'(M);

    state_t              state, state_n;
    logic [IDX_W-1:0]    bit_idx, bit_idx_n;
    logic [ONES_W-1:0]   ones, ones_n, ones_sum;
    bool_t               done_n, error_n, abort_n, last_bit, restart;

    // Next-state logic: symbol framing, bit counting and result decode.
    always_comb begin
        state_n   = state;
        bit_idx_n = bit_idx;
        ones_n    = ones;
        done_n    = 1'b0;
        error_n   = 1'b0;
        abort_n   = 1'b0;
        restart   = 1'b0;
        ones_sum  = ones + ONES_W'(serial_in);
        last_bit  = bit_valid && (bit_idx == LAST_IDX);

        case (state)
            HUNT: begin
                if (sync) begin
                    state_n = COLLECT;
                    restart = 1'b1;
                end
            end
            COLLECT: begin
                // A sync on the final bit lets that symbol complete normally.
                if (sync && !last_bit) begin
                    restart = 1'b1;
                    abort_n = (bit_idx != '0);
                end else if (bit_valid) begin
                    if (bit_idx == LAST_IDX) begin
                        done_n    = 1'b1;
                        error_n   = (ones_sum != M_ONES);
                        bit_idx_n = '0;
                        ones_n    = '0;
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                        ones_n    = ones_sum;
                    end
                end
            end
            default: state_n = HUNT;
        endcase

        // On sync, a coincident valid bit becomes bit 0 of the new symbol.
        if (restart) begin
            bit_idx_n = bit_valid ? IDX_W'(1) : '0;
            ones_n    = bit_valid ? ONES_W'(serial_in) : '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= HUNT;
            bit_idx <= '0;
            ones    <= '0;
        end else begin
            state   <= state_n;
            bit_idx <= bit_idx_n;
            ones    <= ones_n;
        end
    end

    // Registered result pulses and sticky error (clear applies before set).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sym_done   <= 1'b0;
            sym_error  <= 1'b0;
            sym_abort  <= 1'b0;
            sticky_err <= 1'b0;
        end else begin
            sym_done   <= done_n;
            sym_error  <= error_n;
            sym_abort  <= abort_n;
            sticky_err <= (sticky_err & ~clear_err) | error_n;
        end
    end

`ifdef SERIAL_MOFN_ERRCNT_EN
    sat_counter #(
        .W(CNT_W)
    ) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (error_n),
        .clr     (clear_err),
        .count   (err_count)
    );
`else
    assign err_count = '0;
`endif

    assign dbg_state = (state == COLLECT);

endmodule

// File: doc/serial_m_of_n_checker.md
SERIAL_M_OF_N_CHECKER -- requirements
Module: serial_m_of_n_checker

Interface
REQ-001 The block SHALL have parameter N, default 5, meaning bits per symbol (legal 2..16).
REQ-002 The block SHALL have parameter M, default 2, meaning required ones per symbol (legal 0..N).
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning error counter width.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-006 The block SHALL have port bit_valid, input, 1, meaning serial_in is sampled this cycle.
REQ-007 The block SHALL have port serial_in, input, 1, meaning the serial data bit.
REQ-008 The block SHALL have port sync, input, 1, meaning symbol boundary marker.
REQ-009 The block SHALL have port clear_err, input, 1, meaning clear sticky_err and err_count.
REQ-010 The block SHALL have port sym_done, output, 1, meaning one-cycle pulse when a full symbol completes.
REQ-011 The block SHALL have port sym_error, output, 1, meaning the completed symbol is not M-of-N; valid only with sym_done.
REQ-012 The block SHALL have port sym_abort, output, 1, meaning one-cycle pulse when sync discards a partial symbol.
REQ-013 The block SHALL have port sticky_err, output, 1, meaning at least one sym_error since reset or clear.
REQ-014 The block SHALL have port err_count, output, CNT_W, meaning saturating count of erroneous symbols.

Function
REQ-015 The FSM SHALL have states HUNT and COLLECT; bit index (0..N-1) and ones count (0..N) SHALL be separate counters, not encoded states.
REQ-016 In HUNT, the block SHALL ignore bit_valid bits without sync; a cycle with sync=1 SHALL move the FSM to COLLECT.
REQ-017 With sync=1 and bit_valid=1, the sampled bit SHALL be bit 0 of the new symbol; with sync=1 and bit_valid=0, the next valid bit SHALL be bit 0.
REQ-018 In COLLECT, each valid bit SHALL increment the bit index and add serial_in to the ones count; invalid cycles SHALL hold all state.
REQ-019 On the valid bit with index N-1, sym_done SHALL pulse on the next cycle, sym_error SHALL equal (final ones != M), and the counters SHALL wrap to 0 with the FSM remaining in COLLECT.
REQ-020 Back-to-back symbols SHALL have no dead cycle; bit 0 of the next symbol MAY arrive the cycle after bit N-1.
REQ-021 A sync in COLLECT with bit index != 0 SHALL discard the partial symbol, pulse sym_abort on the next cycle, and produce no sym_done.
REQ-022 A sync coinciding with the bit at index N-1 SHALL complete the current symbol normally and SHALL NOT abort.
REQ-023 sticky_err SHALL set on the cycle sym_error is asserted and hold until clear_err or reset.
REQ-024 err_count SHALL increment by one per sym_error and saturate at 2^CNT_W-1.
REQ-025 When clear_err coincides with a sym_error, the clear SHALL take effect first, giving err_count=1 and sticky_err=1.

Reset
REQ-026 Asserting reset_n=0 SHALL immediately force HUNT, zero counters, and set sym_done=0, sym_error=0, sym_abort=0, sticky_err=0, err_count=0, including in mid-symbol.
REQ-027 After reset release, the first bit SHALL be accepted only with or after a sync.

Configuration
REQ-028 With SERIAL_MOFN_ERRCNT_EN defined, err_count SHALL be implemented per REQ-024/025.
REQ-029 Without SERIAL_MOFN_ERRCNT_EN, err_count SHALL be tied to 0, no counter flops SHALL exist, and sticky_err SHALL be unchanged.

Structure
REQ-030 Package SerialMofNDefs SHALL hold bool_t, state_t {HUNT, COLLECT}, and default N/M/CNT_W constants.
REQ-031 The saturating error counter SHALL be the sub-module sat_counter, parameterised by width, with inc and clr inputs.

Verification
REQ-032 N=5, M=2, sync then bits 1,1,0,0,0 back-to-back -> sym_done one cycle after bit 5, sym_error=0, err_count=0.
REQ-033 Same, bits 1,1,1,0,0 -> sym_error=1, sticky_err=1, err_count=1; clear_err -> both 0.
REQ-034 Bits 1,0, then sync with bit 1 -> sym_abort pulse, no sym_done; following 1,0,0,0 completes the 2-of-5 symbol with sym_error=0.
REQ-035 bit_valid gapped every other cycle over two symbols -> results match the ungapped case; reset_n pulse after bit 3 -> all outputs 0 and HUNT, bits ignored until sync.
REQ-036 CNT_W=2, five bad symbols -> err_count saturates at 3; with macro undefined -> err_count stays 0.
